// File: rtl/coreriscv_axi4_finish_unit_param.sv
// Grant-to-refill forwarder with a parametrised finish FIFO, occupancy count and sticky beat-order error.
// Optional same-cycle finish bypass when CORERISCV_AXI4_FINISH_BYPASS_EN is defined.
module coreriscv_axi4_finish_unit_param #(
  parameter  int unsigned DATA_W    = 64,
  parameter  int unsigned BEATS     = 8,
  parameter  int unsigned HDR_W     = 2,
  parameter  int unsigned MXACT_W   = 2,
  parameter  int unsigned CXACT_W   = 1,
  parameter  int unsigned MGR_ID_W  = 1,
  parameter  int unsigned CLIENT_ID = 1,
  parameter  int unsigned FQ_DEPTH  = 2,
  localparam int unsigned BEAT_W    = $clog2(BEATS),
  localparam int unsigned CNT_W     = $clog2(FQ_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               io_grant_valid,
  output logic               io_grant_ready,
  input  logic [HDR_W-1:0]   io_grant_bits_header_src,
  input  logic [HDR_W-1:0]   io_grant_bits_header_dst,
  input  logic [BEAT_W-1:0]  io_grant_bits_addr_beat,
  input  logic [CXACT_W-1:0] io_grant_bits_client_xact_id,
  input  logic [MXACT_W-1:0] io_grant_bits_manager_xact_id,
  input  logic               io_grant_bits_is_builtin_type,
  input  logic [3:0]         io_grant_bits_g_type,
  input  logic [DATA_W-1:0]  io_grant_bits_data,
  output logic               io_refill_valid,
  input  logic               io_refill_ready,
  output logic [HDR_W-1:0]   io_refill_bits_header_src,
  output logic [HDR_W-1:0]   io_refill_bits_header_dst,
  output logic [BEAT_W-1:0]  io_refill_bits_addr_beat,
  output logic [CXACT_W-1:0] io_refill_bits_client_xact_id,
  output logic [MXACT_W-1:0] io_refill_bits_manager_xact_id,
  output logic               io_refill_bits_is_builtin_type,
  output logic [3:0]         io_refill_bits_g_type,
  output logic [DATA_W-1:0]  io_refill_bits_data,
  output logic               io_finish_valid,
  input  logic               io_finish_ready,
  output logic [HDR_W-1:0]   io_finish_bits_header_src,
  output logic [HDR_W-1:0]   io_finish_bits_header_dst,
  output logic [MXACT_W-1:0] io_finish_bits_manager_xact_id,
  output logic               io_ready,
  output logic [CNT_W-1:0]   io_finish_count,
  output logic               io_beat_err
);

  localparam int unsigned PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int unsigned ENT_W = MXACT_W + MGR_ID_W;

  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              beat_err_q, beat_err_d;
  logic [ENT_W-1:0]  mem_q [FQ_DEPTH];
  logic [ENT_W-1:0]  mem_d [FQ_DEPTH];

  logic             needs_finish, multibeat, gate, fire, enq, deq, wr, rd;
  logic             full, empty;
  logic [ENT_W-1:0] new_entry, head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FQ_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign needs_finish = !(io_grant_bits_is_builtin_type && io_grant_bits_g_type == 4'd0);
  assign multibeat    = io_grant_bits_is_builtin_type ? (io_grant_bits_g_type == 4'd5)
                                                      : (io_grant_bits_g_type == 4'd0);
  assign full         = (count_q == CNT_W'(FQ_DEPTH));
  assign empty        = (count_q == '0);
  assign io_ready     = !full;
  assign gate         = io_ready | !needs_finish;
  assign io_grant_ready  = gate & io_refill_ready;
  assign io_refill_valid = gate & io_grant_valid;
  assign fire         = io_grant_valid & io_grant_ready;
  assign enq          = fire & needs_finish & (!multibeat || beat_cnt_q == BEAT_W'(BEATS - 1));
  assign new_entry    = {io_grant_bits_manager_xact_id, io_grant_bits_header_src[MGR_ID_W-1:0]};
  assign deq          = io_finish_valid & io_finish_ready;

`ifdef CORERISCV_AXI4_FINISH_BYPASS_EN
  // An entry handed straight to an empty, ready consumer never touches the FIFO.
  logic bypass;
  assign bypass          = empty & enq & io_finish_ready;
  assign io_finish_valid = !empty | enq;
  assign head            = empty ? new_entry : mem_q[rd_ptr_q];
  assign wr              = enq & !bypass;
  assign rd              = deq & !empty;
`else
  assign io_finish_valid = !empty;
  assign head            = mem_q[rd_ptr_q];
  assign wr              = enq;
  assign rd              = deq;
`endif

  assign io_finish_bits_header_src      = HDR_W'(CLIENT_ID);
  assign io_finish_bits_header_dst      = HDR_W'(head[MGR_ID_W-1:0]);
  assign io_finish_bits_manager_xact_id = head[ENT_W-1:MGR_ID_W];
  assign io_finish_count                = count_q;
  assign io_beat_err                    = beat_err_q;

  assign io_refill_bits_header_src      = io_grant_bits_header_src;
  assign io_refill_bits_header_dst      = io_grant_bits_header_dst;
  assign io_refill_bits_addr_beat       = io_grant_bits_addr_beat;
  assign io_refill_bits_client_xact_id  = io_grant_bits_client_xact_id;
  assign io_refill_bits_manager_xact_id = io_grant_bits_manager_xact_id;
  assign io_refill_bits_is_builtin_type = io_grant_bits_is_builtin_type;
  assign io_refill_bits_g_type          = io_grant_bits_g_type;
  assign io_refill_bits_data            = io_grant_bits_data;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    beat_err_d = beat_err_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    mem_d      = mem_q;
    if (fire && multibeat) begin
      beat_cnt_d = beat_cnt_q + BEAT_W'(1);
      if (io_grant_bits_addr_beat != beat_cnt_q) beat_err_d = 1'b1;
    end
    if (wr) begin
      mem_d[wr_ptr_q] = new_entry;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (rd) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (wr && !rd)      count_d = count_q + CNT_W'(1);
    else if (rd && !wr) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      beat_cnt_q <= '0;
      beat_err_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int unsigned i = 0; i < FQ_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      beat_err_q <= beat_err_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      mem_q      <= mem_d;
    end
  end

endmodule
